// File: rtl/universal_bin_counter.sv
// Universal N-bit binary counter. It supports synchronous clear, parallel load,
// count enable and up/down direction. The terminal-count flags are decoded
// combinationally from the registered count.
module universal_bin_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic         max_tick,
  output logic         min_tick,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] r;
  logic [N-1:0] r_next;

  // Resolve next count: clear beats load, load beats counting, otherwise hold.
  // Add/subtract stay N bits wide so wrap-around falls out of the discarded carry.
  always_comb begin
    r_next = r;
    if (syn_clr) begin
      r_next = '0;
    end else if (load) begin
      r_next = d;
    end else if (en) begin
      if (up) begin
        r_next = r + ONE;
      end else begin
        r_next = r - ONE;
      end
    end
  end

  // Count register; an active-low reset sampled on the clock edge overrides all inputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r <= '0;
    end else begin
      r <= r_next;
    end
  end

  // Output q directly from the register and decode terminal counts from it.
  always_comb begin
    q        = r;
    max_tick = (r == '1);
    min_tick = (r == '0);
  end

endmodule

// File: tb/tb_universal_bin_counter.sv
// Self-checking bench for universal_bin_counter with N=3. It runs directed
// scenarios and then randomized traffic against an integer reference model.
module tb_universal_bin_counter;

  localparam int N = 3;
  localparam int M = 1 << N;

  logic         clk;
  logic         reset;
  logic         syn_clr;
  logic         load;
  logic         en;
  logic         up;
  logic [N-1:0] d;
  logic         max_tick;
  logic         min_tick;
  logic [N-1:0] q;

  int tests_run = 0;
  int tests_failed = 0;
  int model = 0;

  universal_bin_counter #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
    .syn_clr(syn_clr),
    .load(load),
    .en(en),
    .up(up),
    .d(d),
    .max_tick(max_tick),
    .min_tick(min_tick),
    .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the result.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: the count is an integer in 0..M-1 and follows the
  // priority rules directly, using modular arithmetic.
  function automatic int ref_next(input int cur, input bit rst_n, input bit clr,
                                  input bit ld, input bit e, input bit u, input int dv);
    if (!rst_n) return 0;
    if (clr)    return 0;
    if (ld)     return dv % M;
    if (e && u) return (cur + 1) % M;
    if (e)      return (cur + M - 1) % M;
    return cur;
  endfunction

  // Drive one cycle of inputs, advance the model, then check every output
  // 1 time unit after the edge.
  task automatic apply(input string tag, input bit rst_n, input bit clr, input bit ld,
                       input bit e, input bit u, input int dv);
    reset   = rst_n;
    syn_clr = clr;
    load    = ld;
    en      = e;
    up      = u;
    d       = N'(dv);
    model   = ref_next(model, rst_n, clr, ld, e, u, dv);
    @(posedge clk);
    #1;
    check({tag, ".q"}, 32'(q), 32'(model));
    check({tag, ".max"}, 32'(max_tick), 32'(model == M - 1));
    check({tag, ".min"}, 32'(min_tick), 32'(model == 0));
  endtask

  initial begin
    int guard;
    reset = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b0; d = '0;

    // Reset dominates load and enable.
    apply("rst_dom", 0, 0, 1, 1, 1, 5);
    check("rst_q0", 32'(q), 0);
    check("rst_min", 32'(min_tick), 1);
    check("rst_max", 32'(max_tick), 0);
    apply("idle", 1, 0, 0, 0, 0, 0);

    // Load with en=0, hold, then clear beats load.
    apply("load3", 1, 0, 1, 0, 0, 3);
    check("load3_lit", 32'(q), 3);
    apply("hold_a", 1, 0, 0, 0, 0, 0);
    apply("hold_b", 1, 0, 0, 0, 0, 0);
    apply("clr_dom", 1, 1, 1, 0, 0, 6);
    check("clr_lit", 32'(q), 0);

    // Count up through the wrap, pause, then resume.
    for (int i = 0; i < 10; i++) apply("up10", 1, 0, 0, 1, 1, 0);
    check("up10_end", 32'(q), 2);
    for (int i = 0; i < 2; i++) apply("pause", 1, 0, 0, 0, 1, 0);
    apply("resume1", 1, 0, 0, 1, 1, 0);
    apply("resume2", 1, 0, 0, 1, 1, 0);
    check("resume_lit", 32'(q), 4);

    // Count down through the wrap from 0 to 7.
    for (int i = 0; i < 10; i++) apply("down10", 1, 0, 0, 1, 0, 0);
    check("down10_end", 32'(q), 2);

    // Count up until min_tick asserts, within a bounded number of cycles.
    guard = 0;
    do begin
      apply("to_min", 1, 0, 0, 1, 1, 0);
      guard++;
    end while (min_tick !== 1'b1 && guard < 16);
    check("to_min_cycles", 32'(guard), 6);
    for (int i = 0; i < 4; i++) apply("down4", 1, 0, 0, 1, 0, 0);
    check("down4_lit", 32'(q), 4);
    for (int i = 0; i < 4; i++) apply("hold4", 1, 0, 0, 0, 0, 0);

    // Reset in the middle of a count, then resume counting from 0.
    apply("ld5", 1, 0, 1, 0, 1, 5);
    apply("mid_rst", 0, 0, 0, 1, 1, 0);
    check("mid_rst_lit", 32'(q), 0);
    apply("post1", 1, 0, 0, 1, 1, 0);
    apply("post2", 1, 0, 0, 1, 1, 0);
    check("post2_lit", 32'(q), 2);

    // Randomized traffic with weighted control inputs.
    for (int i = 0; i < 400; i++) begin
      apply("rand",
            $urandom_range(0, 19) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, M - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
